// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the ARM MEM-stage external SRAM controller.
// Holds the controller state encoding and the SRAM geometry defaults.
package arm_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } mem_state_e;

    localparam int unsigned BASE_ADDR_DEF = 32'd1024;
    localparam int unsigned SRAM_DATA_W   = 32'd16;
    localparam int unsigned SRAM_ADDR_W   = 32'd18;
    localparam int unsigned WAIT_W        = 32'd4;

endpackage

// File: rtl/sram_wait_counter.sv
// Per-half-word wait-state counter: counts 0..WAIT_CYCLES-1 and flags the
// final cycle of a phase. clr has priority over en.
module sram_wait_counter
    import arm_mem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 32'd2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    output logic [WAIT_W-1:0] count,
    output logic              tc
);

    localparam logic [WAIT_W-1:0] LAST = WAIT_W'(WAIT_CYCLES - 32'd1);

    logic [WAIT_W-1:0] count_q;
    logic [WAIT_W-1:0] count_d;

    // Next count: clear, wrap at terminal count, or advance
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = {WAIT_W{1'b0}};
        end else if (en) begin
            count_d = (count_q == LAST) ? {WAIT_W{1'b0}} : count_q + {{(WAIT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {WAIT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tc    = (count_q == LAST);

endmodule

// File: rtl/sram_mem_controller.sv
// Sequences 32-bit MEM-stage loads/stores as two half-word accesses on a
// 16-bit asynchronous SRAM; ready drops while an access is in flight.
module sram_mem_controller
    import arm_mem_pkg::*;
#(
    parameter int unsigned BASE_ADDR   = BASE_ADDR_DEF,
    parameter int unsigned ADDR_W      = SRAM_ADDR_W,
    parameter int unsigned WAIT_CYCLES = 32'd2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [ADDR_W-1:0]      sram_addr,
    output logic [SRAM_DATA_W-1:0] sram_dq_o,
    input  logic [SRAM_DATA_W-1:0] sram_dq_i,
    output logic                   sram_dq_oe,
    output logic                   sram_ce_n,
    output logic                   sram_oe_n,
    output logic                   sram_we_n
);

    localparam logic [WAIT_W-1:0] PRE_LAST = WAIT_W'(WAIT_CYCLES - 32'd2);

    mem_state_e               state_q, state_d;
    logic                     is_wr_q, is_wr_d;
    logic [ADDR_W-2:0]        off_q, off_d;
    logic [31:0]              wdata_q, wdata_d;
    logic [SRAM_DATA_W-1:0]   rd_lo_q, rd_lo_d;
    logic [31:0]              read_data_q, read_data_d;
    logic [ADDR_W-1:0]        sram_addr_q, sram_addr_d;
    logic [SRAM_DATA_W-1:0]   dq_o_q, dq_o_d;
    logic                     dq_oe_q, dq_oe_d;
    logic                     ce_n_q, ce_n_d;
    logic                     oe_n_q, oe_n_d;
    logic                     we_n_q, we_n_d;

    logic                     cnt_clr_s, cnt_en_s, cnt_tc_s;
    logic [WAIT_W-1:0]        cnt_s;
    logic [31:0]              off_full_s;
    logic                     busy_d_s, half_d_s, last_d_s;
    logic                     unused_off_s;

    assign off_full_s   = address - BASE_ADDR;
    assign unused_off_s = ^{off_full_s[31:ADDR_W+1], off_full_s[1:0]};

    sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr_s),
        .en    (cnt_en_s),
        .count (cnt_s),
        .tc    (cnt_tc_s)
    );

    // Next state, request latching, read capture and pad strobes for the next cycle
    always_comb begin
        state_d     = state_q;
        is_wr_d     = is_wr_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        rd_lo_d     = rd_lo_q;
        read_data_d = read_data_q;
        cnt_clr_s   = 1'b0;
        cnt_en_s    = 1'b0;
        sram_addr_d = sram_addr_q;
        dq_o_d      = dq_o_q;

        case (state_q)
            IDLE: begin
                cnt_clr_s = 1'b1;
                if (mem_write || mem_read) begin
                    is_wr_d = mem_write;
                    off_d   = off_full_s[ADDR_W:2];
                    wdata_d = write_data;
                    state_d = LOW;
                end else begin
                    state_d = IDLE;
                end
            end
            LOW: begin
                if (cnt_tc_s) begin
                    cnt_clr_s = 1'b1;
                    state_d   = HIGH;
                    rd_lo_d   = is_wr_q ? rd_lo_q : sram_dq_i;
                end else begin
                    cnt_en_s = 1'b1;
                end
            end
            HIGH: begin
                if (cnt_tc_s) begin
                    cnt_clr_s   = 1'b1;
                    state_d     = DONE;
                    read_data_d = is_wr_q ? read_data_q : {sram_dq_i, rd_lo_q};
                end else begin
                    cnt_en_s = 1'b1;
                end
            end
            DONE: begin
                cnt_clr_s = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                cnt_clr_s = 1'b1;
                state_d   = IDLE;
            end
        endcase

        // A phase entry restarts the count at 0, which is never the last cycle
        busy_d_s = (state_d == LOW) || (state_d == HIGH);
        half_d_s = (state_d == HIGH);
        last_d_s = cnt_en_s && (cnt_s == PRE_LAST);
        ce_n_d   = ~busy_d_s;
        oe_n_d   = ~(busy_d_s && !is_wr_d);
        dq_oe_d  = busy_d_s && is_wr_d;
        we_n_d   = ~(busy_d_s && is_wr_d && !last_d_s);

        if (busy_d_s) begin
            sram_addr_d = {off_d, half_d_s};
            dq_o_d      = !is_wr_d ? dq_o_q : (half_d_s ? wdata_d[31:16] : wdata_d[15:0]);
        end else begin
            sram_addr_d = sram_addr_q;
            dq_o_d      = dq_o_q;
        end
    end

    // State, latched request and registered pad outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            is_wr_q     <= 1'b0;
            off_q       <= {(ADDR_W-1){1'b0}};
            wdata_q     <= 32'h0000_0000;
            rd_lo_q     <= {SRAM_DATA_W{1'b0}};
            read_data_q <= 32'h0000_0000;
            sram_addr_q <= {ADDR_W{1'b0}};
            dq_o_q      <= {SRAM_DATA_W{1'b0}};
            dq_oe_q     <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            is_wr_q     <= is_wr_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            rd_lo_q     <= rd_lo_d;
            read_data_q <= read_data_d;
            sram_addr_q <= sram_addr_d;
            dq_o_q      <= dq_o_d;
            dq_oe_q     <= dq_oe_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
        end
    end

    assign ready      = (state_q == DONE) || ((state_q == IDLE) && !mem_read && !mem_write);
    assign read_data  = read_data_q;
    assign sram_addr  = sram_addr_q;
    assign sram_dq_o  = dq_o_q;
    assign sram_dq_oe = dq_oe_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed bench for sram_mem_controller with a behavioural SRAM and a
// scoreboard of expected write strobes and load results.
module tb_sram_mem_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] address = 32'h0;
    logic [31:0] write_data = 32'h0;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_o;
    logic [15:0] sram_dq_i;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

    typedef struct packed {
        logic [17:0] a;
        logic [15:0] d;
        logic        oe;
    } wr_t;

    wr_t         wr_log[$];
    wr_t         exp_wr[$];
    logic [31:0] exp_rd[$];
    logic [15:0] mem [0:15];
    int          checks = 0;
    int          errors = 0;
    int          starts = 0;
    logic        prev_ce_n = 1'b1;

    sram_mem_controller dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .sram_addr(sram_addr), .sram_dq_o(sram_dq_o),
        .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    always #5 clk = ~clk;

    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[3:0]] : 16'h0000;

    // SRAM model and write-strobe monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            mem[sram_addr[3:0]] = sram_dq_o;
            wr_log.push_back({sram_addr, sram_dq_o, sram_dq_oe});
        end
        if (!sram_ce_n && prev_ce_n) starts++;
        prev_ce_n = sram_ce_n;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] d, output int stalls);
        @(negedge clk);
        mem_read = rd; mem_write = wr; address = a; write_data = d;
        #1;
        stalls = 0;
        while (ready !== 1'b1 && stalls < 40) begin
            stalls++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check_writes(input string tag);
        wr_t e, o;
        chk({tag, "_count"}, 64'(wr_log.size()), 64'(exp_wr.size()));
        while (exp_wr.size() > 0 && wr_log.size() > 0) begin
            e = exp_wr.pop_front();
            o = wr_log.pop_front();
            chk(tag, 64'(o), 64'(e));
        end
        wr_log.delete();
        exp_wr.delete();
    endtask

    task automatic check_read(input string tag);
        logic [31:0] e;
        if (exp_rd.size() == 0) begin
            chk({tag, "_queue"}, 64'd0, 64'd1);
        end else begin
            e = exp_rd.pop_front();
            chk(tag, 64'(read_data), 64'(e));
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0;
        #1;
    endtask

    initial begin
        int st;
        int s0;
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;

        // reset held for 3 cycles with no requests
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("rst_ready", 64'(ready), 64'd1);
            chk("rst_ce_n", 64'(sram_ce_n), 64'd1);
        end
        chk("rst_outs", 64'({read_data, sram_addr, sram_dq_o, sram_dq_oe, sram_oe_n, sram_we_n}),
            64'({32'h0, 18'h0, 16'h0, 1'b0, 1'b1, 1'b1}));
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("idle_ready", 64'(ready), 64'd1);
            chk("idle_ce_n", 64'(sram_ce_n), 64'd1);
        end
        wr_log.delete();

        // store 0xDEADBEEF to byte 1028 -> half-words 2 and 3
        exp_wr.push_back({18'd2, 16'hBEEF, 1'b1});
        exp_wr.push_back({18'd3, 16'hDEAD, 1'b1});
        do_access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, st);
        chk("store_stalls", 64'(st), 64'd5);
        chk("store_ready_done", 64'(ready), 64'd1);
        go_idle();
        chk("store_idle_ready", 64'(ready), 64'd1);
        check_writes("store_wr");

        // load back from 1028
        exp_rd.push_back(32'hDEADBEEF);
        do_access(1'b1, 1'b0, 32'd1028, 32'h0, st);
        chk("load_stalls", 64'(st), 64'd5);
        check_read("load_data");
        go_idle();
        check_writes("load_nowr");

        // following store must leave read_data alone
        exp_wr.push_back({18'd4, 16'h5678, 1'b1});
        exp_wr.push_back({18'd5, 16'h1234, 1'b1});
        do_access(1'b0, 1'b1, 32'd1032, 32'h12345678, st);
        go_idle();
        check_writes("store2_wr");
        chk("load_hold", 64'(read_data), 64'hDEADBEEF);

        // load held through DONE, then a store the next cycle
        s0 = starts;
        exp_rd.push_back(32'h12345678);
        do_access(1'b1, 1'b0, 32'd1032, 32'h0, st);
        check_read("b2b_load");
        exp_wr.push_back({18'd6, 16'h2222, 1'b1});
        exp_wr.push_back({18'd7, 16'h1111, 1'b1});
        do_access(1'b0, 1'b1, 32'd1036, 32'h11112222, st);
        chk("b2b_store_stalls", 64'(st), 64'd5);
        go_idle();
        chk("b2b_starts", 64'(starts - s0), 64'd2);
        check_writes("b2b_wr");

        // read and write together: write wins
        exp_wr.push_back({18'd0, 16'hF00D, 1'b1});
        exp_wr.push_back({18'd1, 16'hCAFE, 1'b1});
        do_access(1'b1, 1'b1, 32'd1024, 32'hCAFEF00D, st);
        chk("both_stalls", 64'(st), 64'd5);
        go_idle();
        check_writes("both_wr");
        chk("both_rd_hold", 64'(read_data), 64'h12345678);

        // reset asserted during the HIGH half of a store
        @(negedge clk);
        mem_write = 1'b1; address = 32'd1040; write_data = 32'hA5A55A5A;
        repeat (3) @(posedge clk);
        #2;
        chk("midrst_busy_ce", 64'(sram_ce_n), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_strobes", 64'({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}), 64'(4'b1110));
        chk("midrst_addr", 64'(sram_addr), 64'd0);
        chk("midrst_rd", 64'(read_data), 64'd0);
        mem_write = 1'b0;
        #1;
        chk("midrst_ready", 64'(ready), 64'd1);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("post_rst_ready", 64'(ready), 64'd1);
            chk("post_rst_ce_n", 64'(sram_ce_n), 64'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
